// File: rtl/vram_writer_pkg.sv
// Shared definitions for the VRAM writer: register map, FSM encoding, STATUS layout.
package vram_writer_pkg;

  localparam int LEN_W = 16;

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_DST    = 3'd1;
  localparam logic [2:0] REG_LEN    = 3'd2;
  localparam logic [2:0] REG_FILL   = 3'd3;
  localparam logic [2:0] REG_CTRL   = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;

  localparam int CTRL_START = 0;
  localparam int CTRL_CLR   = 1;

  localparam int ST_BUSY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_DONE = 2;
  localparam int ST_OVF  = 3;
  localparam int ST_ERR  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FILL  = 2'd2
  } state_e;

  function automatic logic [31:0] pack_status(input logic err, input logic ovf,
                                              input logic done, input logic full,
                                              input logic busy);
    logic [31:0] s;
    s          = '0;
    s[ST_ERR]  = err;
    s[ST_OVF]  = ovf;
    s[ST_DONE] = done;
    s[ST_FULL] = full;
    s[ST_BUSY] = busy;
    return s;
  endfunction

endpackage

// File: rtl/vram_writer_if.sv
// CPU data-bus and VRAM write-bus bundle for the VRAM writer.
interface vram_writer_if #(parameter int VADDR_W = 13);
  // Both buses are strobe-only: a dbus write takes effect in every cycle where
  // sel && dbus_wen is high, and exactly one VRAM word is written in every
  // cycle where vbus_wen is high. There is no back-pressure on either side.
  logic               sel;
  logic [15:0]        dbus_addr;
  logic [31:0]        dbus_write;
  logic               dbus_wen;
  logic [31:0]        dbus_read;
  logic [VADDR_W-1:0] vbus_addr;
  logic [31:0]        vbus_write;
  logic               vbus_wen;

  modport master (
    output sel, dbus_addr, dbus_write, dbus_wen,
    input  dbus_read, vbus_addr, vbus_write, vbus_wen
  );

  modport slave (
    input  sel, dbus_addr, dbus_write, dbus_wen,
    output dbus_read, vbus_addr, vbus_write, vbus_wen
  );
endinterface

// File: rtl/vram_writer_fifo.sv
// Push FIFO for DATA words; a push on full succeeds only if a pop frees a slot the same cycle.
module vram_writer_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices coincide.
  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/vram_writer.sv
// VRAM writer: drains CPU-pushed DATA words or block-fills a constant into VRAM.
// Define VRAM_WRITER_IRQ_EN to drive irq from the done flag; otherwise irq is tied low.
module vram_writer
  import vram_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int VADDR_W    = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  vram_writer_if.slave  bus,
  output logic          busy,
  output logic          irq,
  output state_e        state_dbg
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  state_e             state, state_n;
  logic [VADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]   len_q, count_q;
  logic [31:0]        fill_q;
  logic               done_q, ovf_q, err_q;

  logic               fifo_full, fifo_empty, pop, push_ok;
  logic [31:0]        fifo_rdata;
  logic [LW-1:0]      fifo_level;

  logic [2:0]         idx;
  logic               wr, wr_data, wr_dst, wr_len, wr_fill, wr_ctrl, start, clr, active;
  logic               fill_go, fill_last, len0_done, err_set, ovf_set, done_set;
  logic [31:0]        rd_mux;
  logic               unused_addr_bits;

  assign idx     = bus.dbus_addr[2:0];
  assign wr      = bus.sel && bus.dbus_wen;
  assign wr_data = wr && (idx == REG_DATA);
  assign wr_dst  = wr && (idx == REG_DST);
  assign wr_len  = wr && (idx == REG_LEN);
  assign wr_fill = wr && (idx == REG_FILL);
  assign wr_ctrl = wr && (idx == REG_CTRL);
  assign start   = wr_ctrl && bus.dbus_write[CTRL_START];
  assign clr     = wr_ctrl && bus.dbus_write[CTRL_CLR];
  assign unused_addr_bits = ^bus.dbus_addr[15:3];

  assign active  = (state != IDLE);
  assign busy    = active || !fifo_empty;
  assign pop     = (state == DRAIN) && !fifo_empty;
  assign push_ok = wr_data && (!fifo_full || pop);
  assign ovf_set = wr_data && fifo_full && !pop;
  assign err_set = (start && busy) || ((wr_dst || wr_len) && active);
  assign done_set = fill_last || len0_done;
  assign state_dbg = state;

  vram_writer_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_data),
    .pop   (pop),
    .wdata (bus.dbus_write),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Pending DATA words take priority over a fill; a start seen with words queued is an error.
  always_comb begin
    state_n   = state;
    fill_go   = 1'b0;
    fill_last = 1'b0;
    len0_done = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_n = DRAIN;
        end else if (start) begin
          if (len_q == '0) begin
            len0_done = 1'b1;
          end else begin
            state_n = FILL;
            fill_go = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (fifo_empty || (fifo_level == LW'(1) && !push_ok)) state_n = IDLE;
      end
      FILL: begin
        if (count_q == LEN_W'(1)) begin
          state_n   = IDLE;
          fill_last = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.vbus_wen   = pop || (state == FILL);
    bus.vbus_addr  = dst_q;
    bus.vbus_write = (state == FILL) ? fill_q : fifo_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_q   <= '0;
      len_q   <= '0;
      fill_q  <= '0;
      count_q <= '0;
    end else begin
      if (bus.vbus_wen)          dst_q <= dst_q + VADDR_W'(1);
      else if (wr_dst && !active) dst_q <= bus.dbus_write[VADDR_W-1:0];
      if (wr_len && !active)     len_q <= bus.dbus_write[LEN_W-1:0];
      if (wr_fill)               fill_q <= bus.dbus_write;
      if (fill_go)               count_q <= len_q;
      else if (state == FILL)    count_q <= count_q - LEN_W'(1);
    end
  end

  // Sticky flags: a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (done_set)  done_q <= 1'b1;
      else if (clr)  done_q <= 1'b0;
      if (ovf_set)   ovf_q  <= 1'b1;
      else if (clr)  ovf_q  <= 1'b0;
      if (err_set)   err_q  <= 1'b1;
      else if (clr)  err_q  <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (idx)
      REG_DST:    rd_mux = 32'(dst_q);
      REG_LEN:    rd_mux = 32'(len_q);
      REG_FILL:   rd_mux = fill_q;
      REG_STATUS: rd_mux = pack_status(err_q, ovf_q, done_q, fifo_full, busy);
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.dbus_read <= '0;
    else        bus.dbus_read <= bus.sel ? rd_mux : '0;
  end

`ifdef VRAM_WRITER_IRQ_EN
  assign irq = done_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_vram_writer.sv
// Directed self-checking bench for vram_writer: drain, wrapping fill, overflow/error, LEN=0, mid-fill reset.
module tb_vram_writer;
  import vram_writer_pkg::*;

  localparam int VADDR_W    = 13;
  localparam int FIFO_DEPTH = 4;
  localparam int QW         = VADDR_W + 32;
`ifdef VRAM_WRITER_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  logic   clk   = 1'b0;
  logic   rst_n = 1'b1;
  logic   busy, irq;
  state_e state_dbg;

  vram_writer_if #(.VADDR_W(VADDR_W)) bus ();

  vram_writer #(.FIFO_DEPTH(FIFO_DEPTH), .VADDR_W(VADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .busy      (busy),
    .irq       (irq),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks  = 0;
  int n_fail    = 0;
  int wr_seen   = 0;
  int extra_cnt = 0;
  logic [QW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [VADDR_W-1:0] addr, input logic [31:0] data);
    exp_q.push_back({addr, data});
  endtask

  always @(negedge clk) begin
    if (bus.vbus_wen === 1'b1) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        extra_cnt++;
      end else begin
        logic [QW-1:0] e;
        e = exp_q.pop_front();
        check("vbus_word", 64'({bus.vbus_addr, bus.vbus_write}), 64'(e));
      end
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic bus_idle();
    bus.sel        = 1'b0;
    bus.dbus_wen   = 1'b0;
    bus.dbus_addr  = '0;
    bus.dbus_write = '0;
  endtask

  task automatic cpu_write(input logic [2:0] idx, input logic [31:0] data);
    bus.sel        = 1'b1;
    bus.dbus_wen   = 1'b1;
    bus.dbus_addr  = {13'd0, idx};
    bus.dbus_write = data;
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic cpu_read(input logic [2:0] idx, output logic [31:0] data);
    bus.sel       = 1'b1;
    bus.dbus_wen  = 1'b0;
    bus.dbus_addr = {13'd0, idx};
    @(posedge clk); #1;
    data = bus.dbus_read;
    bus_idle();
  endtask

  task automatic read_check(input string tag, input logic [2:0] idx, input logic [31:0] exp);
    logic [31:0] rd;
    cpu_read(idx, rd);
    check(tag, 64'(rd), 64'(exp));
  endtask

  task automatic wait_idle(input string tag);
    int cyc;
    cyc = 0;
    while (busy && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check(tag, 64'(busy), 64'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int cyc;
    bus_idle();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vbus_wen", 64'(bus.vbus_wen), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_irq", 64'(irq), 64'(0));
    check("rst_dbus_read", 64'(bus.dbus_read), 64'(0));
    check("rst_state", 64'(state_dbg), 64'(IDLE));
    rst_n = 1'b1;
    read_check("rst_status", REG_STATUS, 32'h0);
    read_check("rst_dst", REG_DST, 32'h0);

    // Two DATA words drained to consecutive addresses
    cpu_write(REG_DST, 32'h0100);
    push_exp(13'h0100, 32'hA);
    push_exp(13'h0101, 32'hB);
    cpu_write(REG_DATA, 32'hA);
    cpu_write(REG_DATA, 32'hB);
    wait_idle("drain2_idle");
    read_check("drain2_dst", REG_DST, 32'h0102);
    check("drain2_q", 64'(exp_q.size()), 64'(0));

    // Fill wrapping past the top of VRAM
    cpu_write(REG_DST, 32'h1FFE);
    cpu_write(REG_LEN, 32'd4);
    cpu_write(REG_FILL, 32'hFFFF0000);
    push_exp(13'h1FFE, 32'hFFFF0000);
    push_exp(13'h1FFF, 32'hFFFF0000);
    push_exp(13'h0000, 32'hFFFF0000);
    push_exp(13'h0001, 32'hFFFF0000);
    cpu_write(REG_CTRL, 32'h1);
    check("fill_start_latency", 64'(bus.vbus_wen), 64'(1));
    wait_idle("fill_idle");
    read_check("fill_status", REG_STATUS, 32'h4);
    check("fill_irq", 64'(irq), 64'(IRQ_EN));
    read_check("fill_dst_wrap", REG_DST, 32'h0002);
    check("fill_q", 64'(exp_q.size()), 64'(0));
    cpu_write(REG_CTRL, 32'h2);
    read_check("clr_status", REG_STATUS, 32'h0);
    check("clr_irq", 64'(irq), 64'(0));

    // Six back-to-back DATA writes while the drain keeps up
    cpu_write(REG_DST, 32'h0200);
    for (int i = 0; i < 6; i++) push_exp(13'h0200 + 13'(i), 32'h11 + 32'(i));
    for (int i = 0; i < 6; i++) cpu_write(REG_DATA, 32'h11 + 32'(i));
    wait_idle("drain6_idle");
    read_check("drain6_status", REG_STATUS, 32'h0);
    read_check("drain6_dst", REG_DST, 32'h0206);
    check("drain6_q", 64'(exp_q.size()), 64'(0));

    // Fill of 10 with DATA pushes (overflow), a second start and a DST write during it
    cpu_write(REG_DST, 32'h0300);
    cpu_write(REG_LEN, 32'd10);
    cpu_write(REG_FILL, 32'h5A5A5A5A);
    for (int i = 0; i < 10; i++) push_exp(13'h0300 + 13'(i), 32'h5A5A5A5A);
    for (int i = 0; i < 4; i++)  push_exp(13'h030A + 13'(i), 32'h21 + 32'(i));
    cpu_write(REG_CTRL, 32'h1);
    for (int i = 0; i < 6; i++) cpu_write(REG_DATA, 32'h21 + 32'(i));
    cpu_write(REG_CTRL, 32'h1);
    cpu_write(REG_DST, 32'h0777);
    wait_idle("ovf_idle");
    read_check("ovf_status", REG_STATUS, 32'h1C);
    read_check("ovf_dst", REG_DST, 32'h030E);
    read_check("ovf_len", REG_LEN, 32'd10);
    check("ovf_q", 64'(exp_q.size()), 64'(0));
    cpu_write(REG_CTRL, 32'h2);
    read_check("ovf_clr_status", REG_STATUS, 32'h0);

    // LEN=0 start completes at once with no VRAM writes
    cpu_write(REG_LEN, 32'd0);
    base = wr_seen;
    cpu_write(REG_CTRL, 32'h1);
    check("len0_busy", 64'(busy), 64'(0));
    read_check("len0_status", REG_STATUS, 32'h4);
    repeat (3) @(posedge clk);
    #1;
    check("len0_no_writes", 64'(wr_seen - base), 64'(0));
    cpu_write(REG_CTRL, 32'h2);

    // Reset in the middle of a 10-word fill
    cpu_write(REG_DST, 32'h0400);
    cpu_write(REG_LEN, 32'd10);
    cpu_write(REG_FILL, 32'h12345678);
    for (int i = 0; i < 10; i++) push_exp(13'h0400 + 13'(i), 32'h12345678);
    base = wr_seen;
    cpu_write(REG_CTRL, 32'h1);
    cyc = 0;
    while ((wr_seen - base) < 3 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("mid_rst_words", 64'(wr_seen - base), 64'(3));
    rst_n = 1'b0;
    #1;
    check("mid_rst_wen", 64'(bus.vbus_wen), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_irq", 64'(irq), 64'(0));
    check("mid_rst_state", 64'(state_dbg), 64'(IDLE));
    check("mid_rst_q", 64'(exp_q.size()), 64'(7));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    read_check("post_rst_dst", REG_DST, 32'h0);
    read_check("post_rst_len", REG_LEN, 32'h0);
    read_check("post_rst_fill", REG_FILL, 32'h0);
    read_check("post_rst_status", REG_STATUS, 32'h0);
    read_check("post_rst_unmapped", 3'd7, 32'h0);
    check("post_rst_no_writes", 64'(wr_seen - base), 64'(3));

    check("no_extra_writes", 64'(extra_cnt), 64'(0));
    check("exp_q_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
